// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_CH CPU request channels onto a single cache/memory port.
// Applies the kseg0/kseg1 address mapping and survives pipeline flushes mid-transaction.
module mem_req_arbiter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned ID_W     = 1
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic [NUM_CH-1:0]              ch_req_i,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_wen_i,
  input  logic [NUM_CH*32-1:0]           ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata_i,
  output logic [NUM_CH*DATA_W-1:0]       ch_rdata_o,
  output logic [NUM_CH-1:0]              ch_ok_o,
  output logic [NUM_CH-1:0]              ch_stall_o,
  output logic                           mem_req_o,
  output logic [(DATA_W/8)-1:0]          mem_wen_o,
  output logic [31:0]                    mem_addr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  output logic                           mem_cached_o,
  output logic [ID_W-1:0]                mem_ch_o,
  input  logic                           mem_ok_i,
  input  logic [DATA_W-1:0]              mem_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [BE_W-1:0]     mem_wen_q, mem_wen_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_cached_q, mem_cached_d;
  logic [IDX_W-1:0]    own_q, own_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   ch_ok_q, ch_ok_d;
  logic [DATA_W-1:0]   rdata_q [NUM_CH];
  logic [DATA_W-1:0]   rdata_d [NUM_CH];

  logic [BE_W-1:0]     wen_a   [NUM_CH];
  logic [31:0]         addr_a  [NUM_CH];
  logic [DATA_W-1:0]   wdata_a [NUM_CH];

  logic [NUM_CH-1:0]   elig;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  int unsigned         base;
  int unsigned         cand;
  logic [31:0]         sel_addr;

  // Unpack flat channel buses into per-channel views.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wen_a[g]   = ch_wen_i[g*BE_W +: BE_W];
    assign addr_a[g]  = ch_addr_i[g*32 +: 32];
    assign wdata_a[g] = ch_wdata_i[g*DATA_W +: DATA_W];
    assign ch_rdata_o[g*DATA_W +: DATA_W] = rdata_q[g];
  end

  // A channel pulsing ok still shows its old request level this cycle.
  assign elig = ch_req_i & ~ch_ok_q;

  // Search upward from base+1; fixed mode pins base so index 0 is tried first.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    base      = (ARB_MODE != 0) ? 32'(rr_ptr_q) : (NUM_CH - 1);
    cand      = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = base + 32'd1 + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!grant_vld && elig[IDX_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign sel_addr = addr_a[grant_idx];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_cached_d = mem_cached_q;
    own_d        = own_q;
    rr_ptr_d     = rr_ptr_q;
    ch_ok_d      = '0;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (!flush_i && grant_vld) begin
          mem_req_d    = 1'b1;
          own_d        = grant_idx;
          rr_ptr_d     = grant_idx;
          mem_wen_d    = wen_a[grant_idx];
          mem_wdata_d  = wdata_a[grant_idx];
          mem_addr_d   = (sel_addr[31:30] == 2'b10) ? {3'b000, sel_addr[28:0]} : sel_addr;
          mem_cached_d = (sel_addr[31:29] != 3'b101);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (mem_ok_i) begin
          mem_req_d = 1'b0;
          mem_wen_d = '0;
          state_d   = IDLE;
          if (!flush_i) begin
            ch_ok_d[own_q] = 1'b1;
            if (mem_wen_q == '0) rdata_d[own_q] = mem_rdata_i;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The in-flight access must finish; its result is dropped.
        if (mem_ok_i) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_wen_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_cached_q <= 1'b0;
      own_q        <= '0;
      rr_ptr_q     <= IDX_W'(NUM_CH - 1);
      ch_ok_q      <= '0;
      rdata_q      <= '{default: '0};
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_cached_q <= mem_cached_d;
      own_q        <= own_d;
      rr_ptr_q     <= rr_ptr_d;
      ch_ok_q      <= ch_ok_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ch_ok_o      = ch_ok_q;
  assign ch_stall_o   = ch_req_i & ~ch_ok_q & ~{NUM_CH{flush_i}};
  assign mem_req_o    = mem_req_q;
  assign mem_wen_o    = mem_wen_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_cached_o = mem_cached_q;
  assign mem_ch_o     = ID_W'(own_q);

endmodule
